// File: rtl/serial_pattern_detect.sv
// Serial pattern detector: matches a PAT_W-bit pattern in an accepted bit stream.
// Ports: clock, clearN (async low), inBit/inValid in, inSyncClr, outMatch/outCount/outSat/outFilled.
module serial_pattern_detect #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              COUNT_W = 8
) (
  input  logic               clock,
  input  logic               clearN,
  input  logic               inBit,
  input  logic               inValid,
  input  logic               inSyncClr,
  output logic               outMatch,
  output logic [COUNT_W-1:0] outCount,
  output logic               outSat,
  output logic               outFilled
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PAT_W-1:0]   hist;
  logic [PAT_W-1:0]   hist_nx;
  logic [PAT_W-1:0]   hist_sh;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_nx;
  logic [FW-1:0]      fill_inc;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_nx;
  logic               match_q;
  logic               match_nx;
  logic               sat;
  logic               sat_nx;
  logic               accept;
  logic               hit;

  // Candidate values for an accepted bit.
  always_comb begin
    accept   = inValid & ~inSyncClr;
    hist_sh  = PAT_W'({hist, inBit});
    fill_inc = (fill == FULL) ? FULL
                              : fill + FW'(1);
    hit      = accept
             && (hist_sh == PATTERN)
             && (fill_inc == FULL);
  end

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill;
    cnt_nx   = cnt;
    sat_nx   = sat;
    match_nx = 1'b0;
    unique case (1'b1)
      inSyncClr: begin
        state_nx = FILL;
        hist_nx  = '0;
        fill_nx  = '0;
        cnt_nx   = '0;
        sat_nx   = 1'b0;
      end
      accept: begin
        hist_nx  = hist_sh;
        fill_nx  = fill_inc;
        match_nx = hit;
        unique case (state)
          FILL: begin
            if (fill_inc == FULL)
              state_nx = RUN;
          end
          RUN: begin
            state_nx = RUN;
          end
          default: begin
            state_nx = FILL;
          end
        endcase
        if (hit) begin
          if (cnt != '1)
            cnt_nx = cnt + COUNT_W'(1);
          if (cnt_nx == '1)
            sat_nx = 1'b1;
          // Non-overlap: demand PAT_W fresh bits.
          if (!OVERLAP) begin
            fill_nx  = '0;
            state_nx = FILL;
          end
        end
      end
      default: begin
        match_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clearN) begin
    if (!clearN) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state   <= state_nx;
      hist    <= hist_nx;
      fill    <= fill_nx;
      cnt     <= cnt_nx;
      sat     <= sat_nx;
      match_q <= match_nx;
    end
  end

  assign outMatch  = match_q;
  assign outCount  = cnt;
  assign outSat    = sat;
  assign outFilled = (state == RUN);

endmodule
